// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// ============================================================================
// Module   : firebird7_in_gate1_tessent_tdr_pkg
// Brief    : Shared field layout and sizing helpers for the gate1 select TDR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package firebird7_in_gate1_tessent_tdr_pkg;

    // Control-bit positions counted above the data field (sr[DW + IDX]).
    localparam int SEL_EN_IDX = 1;
    localparam int PULSE_IDX  = 0;

    typedef struct packed {
        logic sel_en;
        logic pulse_mode;
    } tdr_ctrl_t;

    function automatic int hold_cnt_width(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_select_hold_timer.sv
// ============================================================================
// Module   : firebird7_in_gate1_tessent_select_hold_timer
// Brief    : Loadable down-counter that times the pulse-mode select window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module firebird7_in_gate1_tessent_select_hold_timer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic clear_i,
    output logic active_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(HOLD_CYCLES);
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_o = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_select_ctl.sv
// ============================================================================
// Module   : firebird7_in_gate1_tessent_tdr_select_ctl
// Brief    : IJTAG TDR driving the gate1 data-mux select and IJTAG data input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module firebird7_in_gate1_tessent_tdr_select_ctl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 3,
    parameter int                    HOLD_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA  = '0
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] capture_data_in,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_out
);

    localparam int SR_W  = DATA_WIDTH + 2;
    localparam int CNT_W = hold_cnt_width(HOLD_CYCLES);

    logic [SR_W-1:0]       sr_q;
    logic [SR_W-1:0]       sr_d;
    tdr_ctrl_t             upd_ctrl_q;
    tdr_ctrl_t             upd_ctrl_d;
    logic [DATA_WIDTH-1:0] upd_data_q;
    logic [DATA_WIDTH-1:0] upd_data_d;

    logic      do_update;
    tdr_ctrl_t sr_ctrl;
    logic      timer_load;
    logic      timer_clear;
    logic      hold_active;

    assign do_update          = ijtag_sel & ijtag_ue;
    assign sr_ctrl.sel_en     = sr_q[DATA_WIDTH + SEL_EN_IDX];
    assign sr_ctrl.pulse_mode = sr_q[DATA_WIDTH + PULSE_IDX];

    // Capture has priority over shift; both leave sr alone when deselected.
    always_comb begin
        sr_d = sr_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d = {ijtag_select, upd_ctrl_q.pulse_mode, capture_data_in};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[SR_W-1:1]};
            end
        end
    end

    always_comb begin
        upd_ctrl_d = upd_ctrl_q;
        upd_data_d = upd_data_q;
        if (do_update) begin
            upd_ctrl_d = sr_ctrl;
            upd_data_d = sr_q[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_q       <= '0;
            upd_ctrl_q <= '0;
            upd_data_q <= RESET_DATA;
        end else begin
            sr_q       <= sr_d;
            upd_ctrl_q <= upd_ctrl_d;
            upd_data_q <= upd_data_d;
        end
    end

    // Any update either arms a fresh pulse window or cancels a running one.
    assign timer_load  = do_update & sr_ctrl.sel_en & sr_ctrl.pulse_mode;
    assign timer_clear = do_update & ~timer_load;

    firebird7_in_gate1_tessent_select_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk_i    (ijtag_tck),
        .rst_i    (ijtag_reset),
        .load_i   (timer_load),
        .clear_i  (timer_clear),
        .active_o (hold_active)
    );

    assign ijtag_select   = upd_ctrl_q.sel_en & (~upd_ctrl_q.pulse_mode | hold_active);
    assign ijtag_data_out = upd_data_q;
    assign ijtag_so       = sr_q[0];

endmodule

`default_nettype wire
